exec_core: RTL and testbench
============================

# exec_core

Parametrised execution core: an architectural register file plus ALU with a valid/ready instruction port and an iterative multi-cycle multiply/divide unit. Successor to the single-cycle 4-bit core: data width and register count are generic, results are registered, and arithmetic flags and writeback are committed on a defined cycle. It sits between the instruction source (pin decoder or a sequencer) and the output pins / status logic.

## Interface

- DATA_W, 8, operand/result/register width (≥ 2)
- REG_AW, 3, register address width; NUM_REGS = 2**REG_AW
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inst_valid  in  1  instruction offered
- inst_ready  out  1  core can accept; high only in IDLE
- inst  in  3*REG_AW+5  {we, rd, rs1, rs2, func[3:0]}, func in bits [3:0], we in MSB
- res_valid  out  1  one-cycle pulse, result/flags valid
- res_data  out  DATA_W  result, held until next res_valid
- res_zero  out  1  res_data == 0
- res_carry  out  1  ADD carry-out / SUB borrow / MUL high half non-zero; 0 otherwise
- res_dz  out  1  DIV or MOD with rs2 value 0
- dbg_addr  in  REG_AW  debug read address
- dbg_data  out  DATA_W  combinational read of register dbg_addr

## Operation

- Accept when inst_valid && inst_ready at a rising edge; fields captured, operands read from register file that same cycle.
- Register 0 reads as 0; writes to it discarded. All other registers reset to 0.
- func: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ADD, 7 SUB, 8 MUL, 9 DIV, 10 MOD, 11 SLT, 12 SGT, 13 SEQ, 14 SHL, 15 SHR.
- All operands unsigned. ADD/SUB modulo 2**DATA_W. MUL returns low DATA_W bits of product. SLT/SGT/SEQ return 1 or 0. SHL/SHR shift rs1 by rs2 value; amount ≥ DATA_W gives 0.
- DIV/MOD by zero: quotient all-ones, remainder = rs1, res_dz=1, completes as single-cycle op.
- FSM states: IDLE, MULDIV. IDLE→MULDIV on accepted MUL, or DIV/MOD with non-zero divisor; MULDIV→IDLE when iteration count reaches DATA_W. All other ops stay in IDLE.
- Writeback: if we=1 and rd≠0, res_data written to rd on the same edge res_valid rises. rd==rs1 or rs2 legal; operands are the values captured at accept.
- Instructions offered while busy are not accepted; producer holds inst stable until inst_ready.
- Reset mid-operation: MULDIV aborted, no writeback, FSM to IDLE.

## Timing

- Reset values: inst_ready=1, res_valid=0, res_data=0, res_zero=0 (flags all 0), dbg_data=0.
- Single-cycle op accepted at edge N: res_valid high in cycle following edge N, i.e. latency 1; inst_ready stays high, so back-to-back throughput is 1/cycle.
- MUL/DIV/MOD accepted at edge N: inst_ready low from N; DATA_W iterations on edges N+1..N+DATA_W; res_valid and inst_ready high after edge N+DATA_W (latency DATA_W).
- Instruction accepted in the cycle res_valid is high sees the just-written value (register file updated at that edge; no bypass needed).
- dbg_data combinational, reflects writes after the writeback edge.

## Structure

- Package exec_pkg: func encoding constants, FSM state typedef, instruction field offset functions of REG_AW.
- Sub-module exec_muldiv: shift-add multiplier and restoring divider sharing one DATA_W-step counter; start/done handshake, outputs product low/high, quotient, remainder.
- Top holds register file, single-cycle ALU, FSM, result/flag registers.

## Test plan

- Reset mid-DIV (DATA_W=8): load r1=200, r2=7, issue DIV r3; assert rst_n low after 3 cycles -> all outputs at reset values, r3 reads 0 via dbg.
- ADD r3=r1+r2 with r1=200, r2=100 -> res_data=44, res_carry=1, r3=44 one cycle after accept.
- Back-to-back: ADD r3=r1+r1 then SUB r4=r3-r1 (r1=5) in consecutive cycles -> results 10 then 5, two consecutive res_valid pulses.
- MUL r5=r1*r2 with r1=20, r2=13 -> inst_ready low 8 cycles, res_data=4, res_carry=1; inst_valid held during busy not accepted.
- DIV and MOD with r1=200, r2=7 -> 28 and 4 after 8 cycles; with r2=0 -> 255/200, res_dz=1, 1-cycle latency.
- Write to r0 with we=1 -> dbg_data for r0 stays 0; SHL with rs2 value 9 -> res_data=0, res_zero=1.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execution core: function codes, FSM states and
// instruction field offsets for a given register address width.
package exec_pkg;

   localparam logic [3:0] F_AND  = 4'd0;
   localparam logic [3:0] F_OR   = 4'd1;
   localparam logic [3:0] F_XOR  = 4'd2;
   localparam logic [3:0] F_NAND = 4'd3;
   localparam logic [3:0] F_NOR  = 4'd4;
   localparam logic [3:0] F_XNOR = 4'd5;
   localparam logic [3:0] F_ADD  = 4'd6;
   localparam logic [3:0] F_SUB  = 4'd7;
   localparam logic [3:0] F_MUL  = 4'd8;
   localparam logic [3:0] F_DIV  = 4'd9;
   localparam logic [3:0] F_MOD  = 4'd10;
   localparam logic [3:0] F_SLT  = 4'd11;
   localparam logic [3:0] F_SGT  = 4'd12;
   localparam logic [3:0] F_SEQ  = 4'd13;
   localparam logic [3:0] F_SHL  = 4'd14;
   localparam logic [3:0] F_SHR  = 4'd15;

   typedef enum logic {S_IDLE, S_MULDIV} state_t;

   // Instruction layout, LSB first: func[3:0], rs2, rs1, rd, we
   localparam int RS2_LO = 4;
   function automatic int rs1_lo(input int aw); return 4 + aw;     endfunction
   function automatic int rd_lo (input int aw); return 4 + 2 * aw; endfunction
   function automatic int we_bit(input int aw); return 4 + 3 * aw; endfunction
   function automatic int inst_w(input int aw); return 5 + 3 * aw; endfunction

endpackage

// File: rtl/exec_muldiv.sv
// Iterative unsigned multiply / divide. One DATA_W-step counter drives either
// a shift-add multiplier or a restoring divider over the same hi/lo registers.
// Outputs are the values the registers take on the final step, so done marks
// the cycle whose closing edge completes the operation.
module exec_muldiv import exec_pkg::*; #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] prod_lo,
   output logic [DATA_W-1:0] prod_hi,
   output logic [DATA_W-1:0] quo,
   output logic [DATA_W-1:0] rem
);
   localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

   logic              busy, div_q;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] m, hi, lo, hi_n, lo_n;
   logic [DATA_W:0]   sum, sh;
   logic              ge;

   // One step: multiply adds m into the upper half and shifts right;
   // divide shifts the next dividend bit into the remainder and trial-subtracts m.
   always_comb begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      sh  = {hi, lo[DATA_W-1]};
      ge  = (sh >= {1'b0, m});
      if (div_q) begin
         hi_n = ge ? DATA_W'(sh - {1'b0, m}) : sh[DATA_W-1:0];
         lo_n = {lo[DATA_W-2:0], ge};
      end else begin
         hi_n = sum[DATA_W:1];
         lo_n = {sum[0], lo[DATA_W-1:1]};
      end
   end

   assign done    = busy && (cnt == CW'(DATA_W - 1));
   assign prod_lo = lo_n;
   assign prod_hi = hi_n;
   assign quo     = lo_n;
   assign rem     = hi_n;

   // Load operands on start, then iterate once per cycle until the last step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         div_q <= 1'b0;
         cnt   <= '0;
         m     <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         div_q <= is_div;
         cnt   <= '0;
         m     <= is_div ? b : a;
         lo    <= is_div ? a : b;
         hi    <= '0;
      end else if (busy) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/exec_core.sv
// Execution core: register file, single-cycle ALU, iterative mul/div and
// registered result/flags with writeback on the result edge.
module exec_core import exec_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        inst_valid,
   output logic                        inst_ready,
   input  logic [inst_w(REG_AW)-1:0]   inst,
   output logic                        res_valid,
   output logic [DATA_W-1:0]           res_data,
   output logic                        res_zero,
   output logic                        res_carry,
   output logic                        res_dz,
   input  logic [REG_AW-1:0]           dbg_addr,
   output logic [DATA_W-1:0]           dbg_data
);
   localparam int NUM_REGS = 2 ** REG_AW;

   state_t            state, state_n;
   logic [DATA_W-1:0] rf [NUM_REGS];
   logic [DATA_W-1:0] a, b, alu_y, md_y;
   logic              alu_c, alu_dz, acc, long_op, md_start, md_done;
   logic              we_q;
   logic [REG_AW-1:0] rd_q;
   logic [3:0]        func_q;
   logic [DATA_W-1:0] prod_lo, prod_hi, quo, rem;

   wire [3:0]        f_func = inst[3:0];
   wire [REG_AW-1:0] f_rs2  = inst[RS2_LO +: REG_AW];
   wire [REG_AW-1:0] f_rs1  = inst[rs1_lo(REG_AW) +: REG_AW];
   wire [REG_AW-1:0] f_rd   = inst[rd_lo(REG_AW) +: REG_AW];
   wire              f_we   = inst[we_bit(REG_AW)];

   assign acc      = inst_valid && inst_ready;
   assign a        = (f_rs1 == '0) ? '0 : rf[f_rs1];
   assign b        = (f_rs2 == '0) ? '0 : rf[f_rs2];
   assign long_op  = (f_func == F_MUL) ||
                     (((f_func == F_DIV) || (f_func == F_MOD)) && (b != '0));
   assign md_start = acc && long_op;
   assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

   // Single-cycle ALU; DIV/MOD entries only matter for the divide-by-zero case
   always_comb begin
      alu_y  = '0;
      alu_c  = 1'b0;
      alu_dz = 1'b0;
      case (f_func)
         F_AND:  alu_y = a & b;
         F_OR:   alu_y = a | b;
         F_XOR:  alu_y = a ^ b;
         F_NAND: alu_y = ~(a & b);
         F_NOR:  alu_y = ~(a | b);
         F_XNOR: alu_y = ~(a ^ b);
         F_ADD:  {alu_c, alu_y} = {1'b0, a} + {1'b0, b};
         F_SUB:  begin alu_y = a - b; alu_c = (a < b); end
         F_DIV:  begin alu_y = '1; alu_dz = 1'b1; end
         F_MOD:  begin alu_y = a;  alu_dz = 1'b1; end
         F_SLT:  alu_y = DATA_W'(a < b);
         F_SGT:  alu_y = DATA_W'(a > b);
         F_SEQ:  alu_y = DATA_W'(a == b);
         F_SHL:  alu_y = (32'(b) >= 32'(DATA_W)) ? '0 : (a << b);
         F_SHR:  alu_y = (32'(b) >= 32'(DATA_W)) ? '0 : (a >> b);
         default: alu_y = '0;
      endcase
   end

   assign md_y = (func_q == F_MUL) ? prod_lo : (func_q == F_DIV) ? quo : rem;

   exec_muldiv #(.DATA_W(DATA_W)) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (md_start),
      .is_div  (f_func != F_MUL),
      .a       (a),
      .b       (b),
      .done    (md_done),
      .prod_lo (prod_lo),
      .prod_hi (prod_hi),
      .quo     (quo),
      .rem     (rem)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // FSM next state: busy only while the iterative unit runs
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (md_start) state_n = S_MULDIV;
         S_MULDIV: if (md_done)  state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      inst_ready = (state == S_IDLE);
   end

   // Hold writeback target and op of a long instruction until it completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         rd_q   <= '0;
         func_q <= F_AND;
      end else if (md_start) begin
         we_q   <= f_we;
         rd_q   <= f_rd;
         func_q <= f_func;
      end
   end

   // Result and flag registers, updated on the completing edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_zero  <= 1'b0;
         res_carry <= 1'b0;
         res_dz    <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (acc && !long_op) begin
            res_valid <= 1'b1;
            res_data  <= alu_y;
            res_zero  <= (alu_y == '0);
            res_carry <= alu_c;
            res_dz    <= alu_dz;
         end else if (md_done) begin
            res_valid <= 1'b1;
            res_data  <= md_y;
            res_zero  <= (md_y == '0);
            res_carry <= (func_q == F_MUL) && (prod_hi != '0);
            res_dz    <= 1'b0;
         end
      end
   end

   // Register file writeback on the same edge as res_valid; r0 never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (acc && !long_op) begin
         if (f_we && (f_rd != '0)) rf[f_rd] <= alu_y;
      end else if (md_done) begin
         if (we_q && (rd_q != '0)) rf[rd_q] <= md_y;
      end
   end

endmodule

// File: tb/tb_exec_core.sv
// Directed bench for exec_core with DATA_W=8, REG_AW=3. Registers are built up
// from r0 using SEQ/ADD sequences since the core has no immediate operand.
module tb_exec_core;
   import exec_pkg::*;

   localparam int DW = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          inst_valid;
   logic          inst_ready;
   logic [3*AW+4:0] inst;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          res_zero, res_carry, res_dz;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc, rdy_hi;

   exec_core #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_zero   (res_zero),
      .res_carry  (res_carry),
      .res_dz     (res_dz),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_dbg(input string tag, input logic [AW-1:0] r, input logic [DW-1:0] exp);
      dbg_addr = r;
      #1;
      chkd(tag, dbg_data, exp);
   endtask

   // Offer one instruction for a single edge; returns 1 time unit after that edge
   task automatic issue(input logic we, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [3:0] fn);
      @(negedge clk);
      inst       = {we, rd, rs1, rs2, fn};
      inst_valid = 1'b1;
      @(posedge clk);
      #1;
      inst_valid = 1'b0;
   endtask

   // rd = v, built MSB first by doubling and adding r7 (which holds 1)
   task automatic load(input logic [AW-1:0] rd, input logic [DW-1:0] v);
      issue(1'b1, rd, 3'd0, 3'd0, F_AND);
      for (int i = DW - 1; i >= 0; i--) begin
         issue(1'b1, rd, rd, rd, F_ADD);
         if (v[i]) issue(1'b1, rd, rd, 3'd7, F_ADD);
      end
   endtask

   // Count edges until res_valid, noting edges where inst_ready was already high
   task automatic wait_res(output int n, output int early);
      n = 0;
      early = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!res_valid && inst_ready) early++;
      end while (!res_valid && n < 20);
   endtask

   initial begin
      rst_n      = 1'b0;
      inst_valid = 1'b0;
      inst       = '0;
      dbg_addr   = '0;
      #12;
      chk1("rst_ready", inst_ready, 1'b1);
      chk1("rst_valid", res_valid, 1'b0);
      chkd("rst_data",  res_data, 8'd0);
      chk1("rst_zero",  res_zero, 1'b0);
      chk1("rst_carry", res_carry, 1'b0);
      chk1("rst_dz",    res_dz, 1'b0);
      chkd("rst_dbg",   dbg_data, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // r7 = 1 via SEQ r0,r0
      issue(1'b1, 3'd7, 3'd0, 3'd0, F_SEQ);
      chkd("seq_one", res_data, 8'd1);

      // ADD with carry-out
      load(3'd1, 8'd200);
      load(3'd2, 8'd100);
      issue(1'b1, 3'd3, 3'd1, 3'd2, F_ADD);
      chk1("add_valid", res_valid, 1'b1);
      chkd("add_data",  res_data, 8'd44);
      chk1("add_carry", res_carry, 1'b1);
      chk1("add_zero",  res_zero, 1'b0);
      chk_dbg("add_wb", 3'd3, 8'd44);

      // Back-to-back dependent ops, no bubble
      load(3'd1, 8'd5);
      @(negedge clk);
      inst = {1'b1, 3'd3, 3'd1, 3'd1, F_ADD};
      inst_valid = 1'b1;
      @(posedge clk); #1;
      chk1("b2b_v1", res_valid, 1'b1);
      chkd("b2b_d1", res_data, 8'd10);
      @(negedge clk);
      inst = {1'b1, 3'd4, 3'd3, 3'd1, F_SUB};
      @(posedge clk); #1;
      chk1("b2b_v2", res_valid, 1'b1);
      chkd("b2b_d2", res_data, 8'd5);
      chk1("b2b_borrow", res_carry, 1'b0);
      @(negedge clk);
      inst_valid = 1'b0;

      // MUL with an ADD held on the port while busy
      load(3'd1, 8'd20);
      load(3'd2, 8'd13);
      @(negedge clk);
      inst = {1'b1, 3'd5, 3'd1, 3'd2, F_MUL};
      inst_valid = 1'b1;
      @(posedge clk); #1;
      chk1("mul_busy", inst_ready, 1'b0);
      @(negedge clk);
      inst = {1'b1, 3'd6, 3'd1, 3'd2, F_ADD};
      wait_res(cyc, rdy_hi);
      chki("mul_lat", cyc, 8);
      chki("mul_ready_early", rdy_hi, 0);
      chkd("mul_data", res_data, 8'd4);
      chk1("mul_carry", res_carry, 1'b1);
      chk_dbg("mul_wb", 3'd5, 8'd4);
      chk_dbg("held_not_taken", 3'd6, 8'd0);
      @(posedge clk); #1;
      inst_valid = 1'b0;
      chk1("held_valid", res_valid, 1'b1);
      chkd("held_data", res_data, 8'd33);

      // DIV / MOD, non-zero divisor
      load(3'd1, 8'd200);
      load(3'd2, 8'd7);
      issue(1'b1, 3'd3, 3'd1, 3'd2, F_DIV);
      chk1("div_busy", inst_ready, 1'b0);
      wait_res(cyc, rdy_hi);
      chki("div_lat", cyc, 8);
      chkd("div_data", res_data, 8'd28);
      chk1("div_dz", res_dz, 1'b0);
      issue(1'b1, 3'd4, 3'd1, 3'd2, F_MOD);
      wait_res(cyc, rdy_hi);
      chki("mod_lat", cyc, 8);
      chkd("mod_data", res_data, 8'd4);
      chk_dbg("mod_wb", 3'd4, 8'd4);

      // DIV / MOD by zero complete in one cycle
      load(3'd2, 8'd0);
      issue(1'b1, 3'd3, 3'd1, 3'd2, F_DIV);
      chk1("dz_div_valid", res_valid, 1'b1);
      chk1("dz_div_ready", inst_ready, 1'b1);
      chkd("dz_div_data", res_data, 8'd255);
      chk1("dz_div_flag", res_dz, 1'b1);
      issue(1'b1, 3'd4, 3'd1, 3'd2, F_MOD);
      chk1("dz_mod_valid", res_valid, 1'b1);
      chkd("dz_mod_data", res_data, 8'd200);
      chk1("dz_mod_flag", res_dz, 1'b1);

      // r0 write discarded
      issue(1'b1, 3'd0, 3'd0, 3'd0, F_XNOR);
      chkd("r0_res", res_data, 8'd255);
      chk_dbg("r0_stays", 3'd0, 8'd0);

      // Shift amount beyond width, in-range shift, compare
      load(3'd2, 8'd9);
      issue(1'b1, 3'd6, 3'd1, 3'd2, F_SHL);
      chkd("shl_big", res_data, 8'd0);
      chk1("shl_zero", res_zero, 1'b1);
      load(3'd2, 8'd7);
      issue(1'b1, 3'd6, 3'd1, 3'd2, F_SHR);
      chkd("shr7", res_data, 8'd1);
      issue(1'b1, 3'd6, 3'd2, 3'd1, F_SLT);
      chkd("slt", res_data, 8'd1);

      // Reset three cycles into a DIV
      issue(1'b1, 3'd3, 3'd1, 3'd2, F_DIV);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_ready", inst_ready, 1'b1);
      chk1("mid_rst_valid", res_valid, 1'b0);
      chkd("mid_rst_data",  res_data, 8'd0);
      chk1("mid_rst_carry", res_carry, 1'b0);
      chk1("mid_rst_dz",    res_dz, 1'b0);
      chk1("mid_rst_zero",  res_zero, 1'b0);
      chk_dbg("mid_rst_r3", 3'd3, 8'd0);
      chk_dbg("mid_rst_r1", 3'd1, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rdy_hi = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (res_valid) rdy_hi++;
      end
      chki("no_late_result", rdy_hi, 0);
      chk_dbg("no_late_wb", 3'd3, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
